// File: rtl/cordic_rot_seq.sv
// cordic_rot_seq: iterative rotation-mode CORDIC stepping an external atan table once per clock.
// Optional gain compensation (extra SCALE state) enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_rot_seq #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    input  logic [WIDTH-1:0]   angle_in,
    output logic [15:0]        lut_index,
    input  logic [31:0]        lut_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   x_out,
    output logic [WIDTH+1:0]   y_out,
    output logic [WIDTH-1:0]   z_out,
    output logic               busy
);
`ifdef CORDIC_GAIN_COMP_EN
    typedef enum logic [2:0] {IDLE, PREROT, ITER, SCALE, DONE} state_t;
    localparam state_t POST = SCALE;
    localparam logic signed [31:0] K = 32'sh4DBA76D4;
    logic signed [WIDTH+33:0] px, py;
`else
    typedef enum logic [2:0] {IDLE, PREROT, ITER, DONE} state_t;
    localparam state_t POST = DONE;
`endif
    state_t                  state_q, state_d;
    logic signed [WIDTH+1:0] x_q, x_d, y_q, y_d, xo_q, xo_d, yo_q, yo_d, xs, ys;
    logic signed [WIDTH-1:0] z_q, z_d, zo_q, zo_d, lv;
    logic [4:0]              i_q, i_d;
    logic                    last;

    assign xs   = x_q >>> i_q;
    assign ys   = y_q >>> i_q;
    assign lv   = WIDTH'($signed(lut_value));
    assign last = i_q == 5'(ITERATIONS - 1);
`ifdef CORDIC_GAIN_COMP_EN
    assign px = (WIDTH+34)'(x_q) * (WIDTH+34)'(K);
    assign py = (WIDTH+34)'(y_q) * (WIDTH+34)'(K);
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d     = {{2{x_in[WIDTH-1]}}, x_in};
                y_d     = {{2{y_in[WIDTH-1]}}, y_in};
                z_d     = angle_in;
                state_d = PREROT;
            end
            PREROT: begin
                // Angles in the second/third quadrant: rotate by 180 deg first
                if (z_q[WIDTH-1] ^ z_q[WIDTH-2]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = {~z_q[WIDTH-1], z_q[WIDTH-2:0]};
                end
                i_d     = 5'd0;
                state_d = ITER;
            end
            ITER: begin
                x_d = z_q[WIDTH-1] ? x_q + ys : x_q - ys;
                y_d = z_q[WIDTH-1] ? y_q - xs : y_q + xs;
                z_d = z_q[WIDTH-1] ? z_q + lv : z_q - lv;
                // Counter freezes on the last step so lut_index holds afterwards
                i_d     = last ? i_q : i_q + 5'd1;
                state_d = last ? POST : ITER;
            end
`ifdef CORDIC_GAIN_COMP_EN
            SCALE: begin
                x_d     = px[WIDTH+32:31];
                y_d     = py[WIDTH+32:31];
                state_d = DONE;
            end
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == DONE && state_q != DONE) begin
            xo_d = x_d;
            yo_d = y_d;
            zo_d = z_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign lut_index = {11'd0, i_q};
    assign x_out     = xo_q;
    assign y_out     = yo_q;
    assign z_out     = zo_q;
endmodule

// File: tb/tb_cordic_rot_seq.sv
// tb_cordic_rot_seq: table, random and corner-sequence checks of cordic_rot_seq (24 and 31 iterations).
module tb_cordic_rot_seq;
    localparam int W   = 32;
    localparam int P30 = 1 << 30;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  EXTRA = 1;
    localparam real GSC   = 0.6072529;
`else
    localparam int  EXTRA = 0;
    localparam real GSC   = 1.0;
`endif

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    logic [W-1:0]  x_in = '0, y_in = '0, angle_in = '0;
    logic          in_valid_a[2], out_ready_a[2], in_ready_a[2], out_valid_a[2], busy_a[2];
    logic [15:0]   lut_index_a[2];
    logic [31:0]   lut_value_a[2];
    logic [W+1:0]  xo_a[2], yo_a[2];
    logic [W-1:0]  zo_a[2];
    int            lut[32];

    for (genvar g = 0; g < 2; g++) begin : g_lut
        assign lut_value_a[g] = lut[lut_index_a[g][4:0]];
    end

    cordic_rot_seq u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .x_in(x_in), .y_in(y_in), .angle_in(angle_in), .lut_index(lut_index_a[0]),
        .lut_value(lut_value_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .x_out(xo_a[0]), .y_out(yo_a[0]), .z_out(zo_a[0]), .busy(busy_a[0])
    );

    cordic_rot_seq #(.ITERATIONS(31)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .x_in(x_in), .y_in(y_in), .angle_in(angle_in), .lut_index(lut_index_a[1]),
        .lut_value(lut_value_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .x_out(xo_a[1]), .y_out(yo_a[1]), .z_out(zo_a[1]), .busy(busy_a[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint wrap34(input longint v);
        return (v <<< 30) >>> 30;
    endfunction

    // Reference: fold to |angle| < 90 deg, then greedy rotation toward zero residual angle
    function automatic void model(input int xi, input int yi, input int ai, input int n,
                                  output longint xo, output longint yo, output int zo);
        longint x = xi, y = yi, t;
        int z = ai;
        if (ai >= P30 || ai < -P30) begin
            x = -x;
            y = -y;
            z = z - 32'sh80000000;
        end
        for (int i = 0; i < n; i++) begin
            t = x;
            if (z >= 0) begin
                x = wrap34(x - (y >>> i));
                y = wrap34(y + (t >>> i));
                z = z - lut[i];
            end else begin
                x = wrap34(x + (y >>> i));
                y = wrap34(y - (t >>> i));
                z = z + lut[i];
            end
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = wrap34((x * 64'sh4DBA76D4) >>> 31);
        y = wrap34((y * 64'sh4DBA76D4) >>> 31);
`endif
        xo = x;
        yo = y;
        zo = z;
    endfunction

    task automatic start(input int s, input int xv, input int yv, input logic [31:0] av);
        chk(in_ready_a[s], "in_ready_before_accept", longint'(in_ready_a[s]), 1);
        x_in = xv;
        y_in = yv;
        angle_in = av;
        in_valid_a[s] = 1;
        @(posedge clk); #1;
        in_valid_a[s] = 0;
    endtask

    // Called 1 time unit after the accepting edge
    task automatic collect(input int s, input bit hs, output longint xr, output longint yr, output int zr);
        int n, lat;
        int lg[$];
        bit ok;
        n = s ? 31 : 24;
        lat = 1;
        while (!out_valid_a[s] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid_a[s]) lg.push_back(int'(lut_index_a[s]));
        end
        chk(lat == n + 2 + EXTRA, "latency", lat, n + 2 + EXTRA);
        ok = lg.size() == n + EXTRA;
        for (int k = 0; k < n && ok; k++) ok = lg[k] == k;
        chk(ok, "lut_index_seq", lg.size(), n + EXTRA);
        xr = longint'($signed(xo_a[s]));
        yr = longint'($signed(yo_a[s]));
        zr = int'($signed(zo_a[s]));
        if (hs) begin
            out_ready_a[s] = 1;
            @(posedge clk); #1;
            out_ready_a[s] = 0;
            chk(!out_valid_a[s] && in_ready_a[s], "release", longint'(out_valid_a[s]), 0);
        end
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [31:0] a;
        longint      ex;
        longint      ey;
        int          tol;
    } vec_t;

    vec_t   vecs[6];
    longint xr, yr, mx, my, e;
    int     zr, mz, xv, yv, s;
    logic [31:0] av;
    bit     ok;

    initial begin
        for (int i = 0; i < 32; i++)
            lut[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 4294967296.0 / (2.0 * 3.14159265358979) + 0.5);
        vecs[0] = '{P30, 0, 32'h00000000,  1768195400,           0, 256};
        vecs[1] = '{P30, 0, 32'h20000000,  1250302600,  1250302600, 512};
        vecs[2] = '{P30, 0, 32'h80000000, -1768195400,           0, 256};
        vecs[3] = '{P30, 0, 32'h60000000, -1250302600,  1250302600, 512};
        vecs[4] = '{P30, 0, 32'h40000000,           0,  1768195400, 256};
        vecs[5] = '{P30, 0, 32'hE0000000,  1250302600, -1250302600, 512};
        for (int k = 0; k < 2; k++) begin
            in_valid_a[k] = 0;
            out_ready_a[k] = 0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk(in_ready_a[0] == 1, "reset_in_ready", longint'(in_ready_a[0]), 1);
        chk(out_valid_a[0] == 0, "reset_out_valid", longint'(out_valid_a[0]), 0);
        chk(busy_a[0] == 0, "reset_busy", longint'(busy_a[0]), 0);
        chk(lut_index_a[0] == 0, "reset_lut_index", longint'(lut_index_a[0]), 0);
        chk(xo_a[0] == 0 && yo_a[0] == 0 && zo_a[0] == 0, "reset_outputs", longint'($signed(xo_a[0])), 0);
        reset = 0;
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            start(0, vecs[k].x, vecs[k].y, vecs[k].a);
            collect(0, 1, xr, yr, zr);
            e = longint'(real'(vecs[k].ex) * GSC);
            chk(xr - e <= vecs[k].tol && e - xr <= vecs[k].tol, "vec_x", xr, e);
            e = longint'(real'(vecs[k].ey) * GSC);
            chk(yr - e <= vecs[k].tol && e - yr <= vecs[k].tol, "vec_y", yr, e);
            chk(zr <= 1024 && zr >= -1024, "vec_z", zr, 0);
        end

        for (int r = 0; r < 16; r++) begin
            s  = r < 12 ? 0 : 1;
            xv = int'($urandom_range(0, 32'h7FFFFFFF)) - 32'sh40000000;
            yv = int'($urandom_range(0, 32'h7FFFFFFF)) - 32'sh40000000;
            av = $urandom;
            model(xv, yv, int'(av), s ? 31 : 24, mx, my, mz);
            start(s, xv, yv, av);
            collect(s, 1, xr, yr, zr);
            chk(xr == mx, "rand_x", xr, mx);
            chk(yr == my, "rand_y", yr, my);
            chk(zr == mz, "rand_z", zr, mz);
        end

        // 31-iteration instance on a known vector
        start(1, P30, 0, 32'h20000000);
        collect(1, 1, xr, yr, zr);
        e = longint'(1250302600.0 * GSC);
        chk(xr - e <= 512 && e - xr <= 512, "it31_x", xr, e);

        // Backpressure: result held, new operands ignored, accept right after handshake
        start(0, P30, 0, 32'h20000000);
        collect(0, 0, xr, yr, zr);
        for (int c = 0; c < 5; c++) begin
            x_in = 32'h20000000;
            y_in = 32'h10000000;
            angle_in = 32'hE0000000;
            in_valid_a[0] = 1;
            @(posedge clk); #1;
            ok = out_valid_a[0] && !in_ready_a[0] && busy_a[0] &&
                 longint'($signed(xo_a[0])) == xr && longint'($signed(yo_a[0])) == yr &&
                 int'($signed(zo_a[0])) == zr;
            chk(ok, "backpressure_hold", longint'($signed(xo_a[0])), xr);
        end
        out_ready_a[0] = 1;
        @(posedge clk); #1;
        out_ready_a[0] = 0;
        chk(!out_valid_a[0] && in_ready_a[0] && !busy_a[0], "handshake_idle", longint'(out_valid_a[0]), 0);
        @(posedge clk); #1;
        in_valid_a[0] = 0;
        chk(busy_a[0] && !in_ready_a[0], "accept_after_handshake", longint'(busy_a[0]), 1);
        model(32'h20000000, 32'h10000000, 32'hE0000000, 24, mx, my, mz);
        collect(0, 1, xr, yr, zr);
        chk(xr == mx, "bp_x", xr, mx);
        chk(yr == my, "bp_y", yr, my);
        chk(zr == mz, "bp_z", zr, mz);

        // Asynchronous reset at iteration 10
        start(0, P30, 0, 32'h20000000);
        for (int c = 0; c < 50 && lut_index_a[0] != 10; c++) begin
            @(posedge clk); #1;
        end
        chk(lut_index_a[0] == 10 && busy_a[0], "reach_iter10", longint'(lut_index_a[0]), 10);
        #2;
        reset = 1;
        #1;
        ok = !out_valid_a[0] && !busy_a[0] && lut_index_a[0] == 0 && in_ready_a[0] &&
             xo_a[0] == 0 && yo_a[0] == 0 && zo_a[0] == 0;
        chk(ok, "async_reset", longint'($signed(xo_a[0])), 0);
        @(posedge clk); #2;
        reset = 0;
        @(posedge clk); #1;
        model(-P30 / 2, P30 / 3, 32'h9ABCDEF0, 24, mx, my, mz);
        start(0, -P30 / 2, P30 / 3, 32'h9ABCDEF0);
        collect(0, 1, xr, yr, zr);
        chk(xr == mx, "post_reset_x", xr, mx);
        chk(yr == my, "post_reset_y", yr, my);
        chk(zr == mz, "post_reset_z", zr, mz);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
